// File: rtl/micro_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : micro_ctrl_pkg
// Description : Encodings, control-word layout and microcode table for the
//               micro-step control decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package micro_ctrl_pkg;

    localparam logic [7:0] c_we_ar = 8'h01;
    localparam logic [7:0] c_we_pc = 8'h02;
    localparam logic [7:0] c_we_dr = 8'h04;
    localparam logic [7:0] c_we_ir = 8'h08;
    localparam logic [7:0] c_we_ra = 8'h10;
    localparam logic [7:0] c_we_rb = 8'h20;
    localparam logic [7:0] c_we_rc = 8'h40;
    localparam logic [7:0] c_we_ac = 8'h80;

    localparam logic [2:0] c_bus_none = 3'd0;
    localparam logic [2:0] c_bus_pc   = 3'd1;
    localparam logic [2:0] c_bus_dr   = 3'd2;
    localparam logic [2:0] c_bus_ac   = 3'd3;
    localparam logic [2:0] c_bus_ra   = 3'd4;
    localparam logic [2:0] c_bus_rb   = 3'd5;
    localparam logic [2:0] c_bus_rc   = 3'd6;
    localparam logic [2:0] c_bus_ir   = 3'd7;

    localparam logic [2:0] c_alu_pass = 3'd0;
    localparam logic [2:0] c_alu_add  = 3'd1;
    localparam logic [2:0] c_alu_sub  = 3'd2;
    localparam logic [2:0] c_alu_mul  = 3'd3;
    localparam logic [2:0] c_alu_inc  = 3'd4;
    localparam logic [2:0] c_alu_clr  = 3'd5;

    typedef struct packed {
        logic [7:0] reg_we;
        logic [2:0] bus_sel;
        logic [2:0] alu_op;
        logic       pc_inc;
        logic       is_rd;
        logic       is_wr;
    } ctrl_word_t;

    localparam ctrl_word_t c_nop = '0;

    typedef ctrl_word_t [63:0] ctrl_rom_t;

    function automatic ctrl_word_t cw(input logic [7:0] we, input logic [2:0] bus,
                                      input logic [2:0] alu, input logic pc,
                                      input logic rd, input logic wr);
        ctrl_word_t w;
        w.reg_we  = we;
        w.bus_sel = bus;
        w.alu_op  = alu;
        w.pc_inc  = pc;
        w.is_rd   = rd;
        w.is_wr   = wr;
        return w;
    endfunction

    // Any code not written below stays a NOP.
    function automatic ctrl_rom_t build_rom();
        ctrl_rom_t rom;
        rom     = '0;
        rom[1]  = cw(c_we_ar, c_bus_pc,   c_alu_pass, 1'b0, 1'b0, 1'b0);
        rom[2]  = cw(c_we_dr, c_bus_none, c_alu_pass, 1'b1, 1'b1, 1'b0);
        rom[3]  = cw(c_we_ir, c_bus_dr,   c_alu_pass, 1'b0, 1'b0, 1'b0);
        rom[4]  = cw(c_we_pc, c_bus_ir,   c_alu_pass, 1'b0, 1'b0, 1'b0);
        rom[5]  = cw(c_we_ra, c_bus_dr,   c_alu_pass, 1'b0, 1'b0, 1'b0);
        rom[6]  = cw(c_we_rb, c_bus_dr,   c_alu_pass, 1'b0, 1'b0, 1'b0);
        rom[7]  = cw(c_we_rc, c_bus_dr,   c_alu_pass, 1'b0, 1'b0, 1'b0);
        rom[8]  = cw(c_we_ar, c_bus_ra,   c_alu_pass, 1'b0, 1'b0, 1'b0);
        rom[9]  = cw(8'h00,   c_bus_ac,   c_alu_pass, 1'b0, 1'b0, 1'b1);
        rom[16] = cw(c_we_ac, c_bus_ac,   c_alu_inc,  1'b0, 1'b0, 1'b0);
        rom[39] = cw(c_we_ac, c_bus_ra,   c_alu_add,  1'b0, 1'b0, 1'b0);
        rom[40] = cw(c_we_ac, c_bus_rb,   c_alu_sub,  1'b0, 1'b0, 1'b0);
        rom[41] = cw(c_we_ac, c_bus_rc,   c_alu_mul,  1'b0, 1'b0, 1'b0);
        rom[55] = cw(c_we_ac, c_bus_none, c_alu_clr,  1'b0, 1'b0, 1'b0);
        rom[56] = c_nop;
        return rom;
    endfunction

    localparam ctrl_rom_t CTRL_ROM = build_rom();

endpackage
`default_nettype wire

// File: rtl/micro_ctrl_rom.sv
`default_nettype none
// ============================================================================
// Module      : micro_ctrl_rom
// Description : Combinational micro-step lookup with illegal-code detection.
// Revision    : 1.0 - initial release
// ============================================================================
module micro_ctrl_rom
    import micro_ctrl_pkg::*;
#(
    parameter int NUM_STEPS = 56
) (
    input  logic [5:0] mIR,
    output ctrl_word_t word,
    output logic       illegal
);

    logic w_illegal;

    assign w_illegal = (mIR == 6'd0) || (32'(mIR) > NUM_STEPS);
    assign illegal   = w_illegal;
    assign word      = w_illegal ? c_nop : CTRL_ROM[mIR];

endmodule
`default_nettype wire

// File: rtl/micro_ctrl_decoder.sv
`default_nettype none
// ============================================================================
// Module      : micro_ctrl_decoder
// Description : Registers the datapath control word per micro-step, holding
//               memory steps until mem_ready or timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module micro_ctrl_decoder
    import micro_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int NUM_STEPS   = 56
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] mIR,
    input  logic       mir_valid,
    input  logic       mem_ready,
    output logic [7:0] reg_we,
    output logic [2:0] bus_sel,
    output logic [2:0] alu_op,
    output logic       pc_inc,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       stall,
    output logic       illegal,
    output logic       mem_err
);

    localparam logic [7:0] c_timeout = 8'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_MEM_WAIT = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [7:0] r_pend_we;
    logic       r_pend_pc;
    ctrl_word_t w_word;
    logic       w_illegal;

    micro_ctrl_rom #(
        .NUM_STEPS (NUM_STEPS)
    ) u_rom (
        .mIR     (mIR),
        .word    (w_word),
        .illegal (w_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_pend_we <= 8'd0;
            r_pend_pc <= 1'b0;
            reg_we    <= 8'd0;
            bus_sel   <= 3'd0;
            alu_op    <= 3'd0;
            pc_inc    <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            stall     <= 1'b0;
            illegal   <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            case (r_state)
                S_MEM_WAIT: begin
                    illegal <= 1'b0;
                    if (mem_ready) begin
                        // Commit the withheld write; bus/alu stay up for this cycle.
                        reg_we  <= r_pend_we;
                        pc_inc  <= r_pend_pc;
                        mem_rd  <= 1'b0;
                        mem_wr  <= 1'b0;
                        stall   <= 1'b0;
                        r_cnt   <= 8'd0;
                        r_state <= S_ISSUE;
                    end else if (r_cnt >= c_timeout) begin
                        reg_we  <= 8'd0;
                        bus_sel <= 3'd0;
                        alu_op  <= 3'd0;
                        pc_inc  <= 1'b0;
                        mem_rd  <= 1'b0;
                        mem_wr  <= 1'b0;
                        stall   <= 1'b0;
                        mem_err <= 1'b1;
                        r_cnt   <= 8'd0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    if (mir_valid) begin
                        illegal <= w_illegal;
                        bus_sel <= w_word.bus_sel;
                        alu_op  <= w_word.alu_op;
                        if (w_word.is_rd || w_word.is_wr) begin
                            reg_we    <= 8'd0;
                            pc_inc    <= 1'b0;
                            mem_rd    <= w_word.is_rd;
                            mem_wr    <= w_word.is_wr & ~w_word.is_rd;
                            stall     <= 1'b1;
                            r_pend_we <= w_word.reg_we;
                            r_pend_pc <= w_word.pc_inc;
                            r_cnt     <= 8'd1;
                            r_state   <= S_MEM_WAIT;
                        end else begin
                            reg_we  <= w_word.reg_we;
                            pc_inc  <= w_word.pc_inc;
                            mem_rd  <= 1'b0;
                            mem_wr  <= 1'b0;
                            stall   <= 1'b0;
                            r_state <= S_ISSUE;
                        end
                    end else begin
                        reg_we  <= 8'd0;
                        bus_sel <= 3'd0;
                        alu_op  <= 3'd0;
                        pc_inc  <= 1'b0;
                        mem_rd  <= 1'b0;
                        mem_wr  <= 1'b0;
                        stall   <= 1'b0;
                        illegal <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_micro_ctrl_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_micro_ctrl_decoder
// Description : Directed self-checking bench for micro_ctrl_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_micro_ctrl_decoder;

    logic       clk;
    logic       rst_n;
    logic [5:0] mIR;
    logic       mir_valid;
    logic       mem_ready;
    logic [7:0] reg_we;
    logic [2:0] bus_sel;
    logic [2:0] alu_op;
    logic       pc_inc;
    logic       mem_rd;
    logic       mem_wr;
    logic       stall;
    logic       illegal;
    logic       mem_err;

    int n_checks = 0;
    int n_fails  = 0;

    micro_ctrl_decoder #(
        .MEM_TIMEOUT (16),
        .NUM_STEPS   (56)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mIR       (mIR),
        .mir_valid (mir_valid),
        .mem_ready (mem_ready),
        .reg_we    (reg_we),
        .bus_sel   (bus_sel),
        .alu_op    (alu_op),
        .pc_inc    (pc_inc),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .stall     (stall),
        .illegal   (illegal),
        .mem_err   (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Packed order: reg_we, bus_sel, alu_op, pc_inc, mem_rd, mem_wr, stall, illegal, mem_err
    task automatic expect_out(input string tag, input logic [7:0] we, input logic [2:0] bus,
                              input logic [2:0] alu, input logic pc, input logic rd,
                              input logic wr, input logic st, input logic il, input logic er);
        check(tag, {12'd0, reg_we, bus_sel, alu_op, pc_inc, mem_rd, mem_wr, stall, illegal, mem_err},
              {12'd0, we, bus, alu, pc, rd, wr, st, il, er});
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            assert (!(mem_rd && mem_wr))
            else $error("FAIL rd_wr_excl: mem_rd and mem_wr both high");
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        mIR       = 6'd0;
        mir_valid = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        expect_out("reset", 8'h00, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Reset while waiting on a read
        @(negedge clk); mir_valid = 1'b1; mIR = 6'd2;
        @(negedge clk); mir_valid = 1'b0;
        expect_out("rst_wait_rd", 8'h00, 3'd0, 3'd0, 0, 1, 0, 1, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        expect_out("rst_async", 8'h00, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); rst_n = 1'b1;

        // Back-to-back non-memory steps 1,3,39,55
        @(negedge clk); mir_valid = 1'b1; mIR = 6'd1;
        @(negedge clk); expect_out("b2b_1",  8'h01, 3'd1, 3'd0, 0, 0, 0, 0, 0, 0); mIR = 6'd3;
        @(negedge clk); expect_out("b2b_3",  8'h08, 3'd2, 3'd0, 0, 0, 0, 0, 0, 0); mIR = 6'd39;
        @(negedge clk); expect_out("b2b_39", 8'h80, 3'd4, 3'd1, 0, 0, 0, 0, 0, 0); mIR = 6'd55;
        @(negedge clk); expect_out("b2b_55", 8'h80, 3'd0, 3'd5, 0, 0, 0, 0, 0, 0); mir_valid = 1'b0;
        @(negedge clk); expect_out("b2b_idle", 8'h00, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0);

        // Read step 2, mem_ready on third wait cycle
        mir_valid = 1'b1; mIR = 6'd2;
        @(negedge clk); mir_valid = 1'b0;
        expect_out("rd_wait1", 8'h00, 3'd0, 3'd0, 0, 1, 0, 1, 0, 0);
        @(negedge clk); expect_out("rd_wait2", 8'h00, 3'd0, 3'd0, 0, 1, 0, 1, 0, 0);
        @(negedge clk); expect_out("rd_wait3", 8'h00, 3'd0, 3'd0, 0, 1, 0, 1, 0, 0);
        mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        expect_out("rd_done", 8'h04, 3'd0, 3'd0, 1, 0, 0, 0, 0, 0);
        @(negedge clk); expect_out("rd_after", 8'h00, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0);
        mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        expect_out("rdy_ignored", 8'h00, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0);

        // Write step 9, sequencer changes mIR to 56 while stalled
        mir_valid = 1'b1; mIR = 6'd9;
        @(negedge clk); expect_out("wr_wait1", 8'h00, 3'd3, 3'd0, 0, 0, 1, 1, 0, 0);
        mIR = 6'd56;
        @(negedge clk); expect_out("wr_wait2", 8'h00, 3'd3, 3'd0, 0, 0, 1, 1, 0, 0);
        @(negedge clk); expect_out("wr_wait3", 8'h00, 3'd3, 3'd0, 0, 0, 1, 1, 0, 0);
        mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        check("wr_done", {21'd0, mem_wr, stall, reg_we, pc_inc, illegal}, 32'd0);
        @(negedge clk); mir_valid = 1'b0;
        expect_out("wr_then_56", 8'h00, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0);

        // Read step 2 that never completes
        @(negedge clk); mir_valid = 1'b1; mIR = 6'd2;
        @(negedge clk); mir_valid = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            expect_out($sformatf("to_wait%0d", i), 8'h00, 3'd0, 3'd0, 0, 1, 0, 1, 0, 0);
            @(negedge clk);
        end
        expect_out("to_abort", 8'h00, 3'd0, 3'd0, 0, 0, 0, 0, 0, 1);
        @(negedge clk); expect_out("to_sticky1", 8'h00, 3'd0, 3'd0, 0, 0, 0, 0, 0, 1);
        mir_valid = 1'b1; mIR = 6'd1;
        @(negedge clk); mir_valid = 1'b0;
        expect_out("to_then_1", 8'h01, 3'd1, 3'd0, 0, 0, 0, 0, 0, 1);

        // Illegal codes around the legal range boundary
        mir_valid = 1'b1; mIR = 6'd0;
        @(negedge clk); expect_out("ill_0",  8'h00, 3'd0, 3'd0, 0, 0, 0, 0, 1, 1); mIR = 6'd60;
        @(negedge clk); expect_out("ill_60", 8'h00, 3'd0, 3'd0, 0, 0, 0, 0, 1, 1); mIR = 6'd57;
        @(negedge clk); expect_out("ill_57", 8'h00, 3'd0, 3'd0, 0, 0, 0, 0, 1, 1); mIR = 6'd56;
        @(negedge clk); expect_out("leg_56", 8'h00, 3'd0, 3'd0, 0, 0, 0, 0, 0, 1); mir_valid = 1'b0;
        @(negedge clk); expect_out("ill_end", 8'h00, 3'd0, 3'd0, 0, 0, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/micro_ctrl_decoder.md
Name: micro_ctrl_decoder

Overview:
Control-store stage directly downstream of the micro-sequencer. Consumes each 6-bit micro-step code (mIR) and drives the registered datapath control word: register write enables, bus source select, ALU op, PC increment and memory strobes. Holds memory micro-steps until the memory reports ready. Back-pressures the sequencer with `stall` while waiting.

Parameters:
- MEM_TIMEOUT, 16, max cycles spent waiting for mem_ready before abort (1..255).
- NUM_STEPS, 56, highest legal micro-step code; codes 0 and codes > NUM_STEPS are illegal.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mIR  in  6  micro-step code from the sequencer.
- mir_valid  in  1  mIR holds a new step; sampled only in cycles where stall==0.
- mem_ready  in  1  memory completed the current access; sampled only in MEM_WAIT.
- reg_we  out  8  one-hot destination enable: bit0 AR, 1 PC, 2 DR, 3 IR, 4 RA, 5 RB, 6 RC, 7 AC.
- bus_sel  out  3  bus source: 0 none, 1 PC, 2 DR, 3 AC, 4 RA, 5 RB, 6 RC, 7 IR.
- alu_op  out  3  0 PASS, 1 ADD, 2 SUB, 3 MUL, 4 INC, 5 CLR.
- pc_inc  out  1  increment PC.
- mem_rd  out  1  memory read strobe (level, held).
- mem_wr  out  1  memory write strobe (level, held).
- stall  out  1  sequencer must hold mIR/mir_valid.
- illegal  out  1  one-cycle pulse: illegal code accepted.
- mem_err  out  1  sticky: memory timeout occurred.

Behaviour:
- Reset (rst_n low, any state, including mid-wait): all outputs 0, state IDLE, timeout counter 0, mem_err cleared.
- The control word for each code comes from the constant table CTRL_ROM. Fields: reg_we, bus_sel, alu_op, pc_inc, is_rd, is_wr.
- Fixed table entries:
  - 1: bus PC, we AR.
  - 2: mem read, we DR, pc_inc.
  - 3: bus DR, we IR.
  - 9: bus AC, mem write.
  - 39: bus RA, alu ADD, we AC.
  - 55: alu CLR, we AC.
  - 56: all zero.
- States: IDLE, ISSUE, MEM_WAIT.
- IDLE/ISSUE, mir_valid=1 and stall=0 at edge N: the word is registered and visible in cycle N+1 (latency 1).
  - Non-memory word: all fields are driven for exactly one cycle (ISSUE), then return to zero unless a new step is accepted back-to-back. Back-to-back steps give one word per cycle.
  - Memory word (is_rd or is_wr): in N+1, mem_rd/mem_wr, bus_sel and alu_op are driven and stall=1. reg_we and pc_inc are withheld. Go to MEM_WAIT; the timeout counter starts at 1.
- MEM_WAIT:
  - The strobe, bus_sel and alu_op are held stable.
  - If mem_ready=1 at edge M: in M+1, reg_we and pc_inc assert for one cycle, strobes drop to 0 and stall=0. Next state is ISSUE-equivalent, so a step can be accepted at the edge ending M+1.
  - If the counter reaches MEM_TIMEOUT without mem_ready: all outputs return to 0, mem_err=1 (sticky until reset), stall=0, go to IDLE. No register write occurs.
- mem_ready outside MEM_WAIT is ignored.
- mir_valid while stall=1 is ignored. The sequencer must hold the step; the decoder does not queue it.
- Illegal code accepted: the NOP word is issued, and illegal pulses in N+1.
- mir_valid=0 with stall=0: outputs are 0 the next cycle.
- is_rd and is_wr are never both set in CTRL_ROM. If both are set, read takes precedence (assertion in the bench).

Decomposition:
- Package micro_ctrl_pkg: register-bit localparams, bus_sel and alu_op encodings, the ctrl_word_t packed struct, and the CTRL_ROM constant array indexed 0..63 (unlisted entries = NOP).
- One sub-module, micro_ctrl_rom: combinational lookup mIR -> ctrl_word_t plus an illegal flag.
- FSM, timeout counter and output registers live in micro_ctrl_decoder.

Test Plan:
- Reset mid-MEM_WAIT (step 2 issued, no mem_ready, rst_n pulsed low) -> all outputs 0 immediately, mem_err=0, stall=0.
- Steps 1,3,39,55 on consecutive cycles -> in the four following cycles:
  - reg_we = 0x01, 0x08, 0x80, 0x80
  - bus_sel = 1, 2, 4, 0
  - alu_op = 0, 0, 1, 5
  - stall = 0 throughout.
- Step 2, mem_ready asserted on the 3rd wait cycle -> mem_rd=1 and stall=1 for 3 cycles; then one cycle of reg_we=0x04 and pc_inc=1 with mem_rd=0.
- Step 9 with mir_valid held and mIR changed to 56 during stall -> code 56 is not accepted until stall drops; mem_wr is held until mem_ready.
- Step 2 with mem_ready never asserted, MEM_TIMEOUT=16 -> after 16 wait cycles all outputs 0, mem_err=1 and stays 1, reg_we never asserted.
- Codes 0 and 60 -> illegal pulses one cycle each, all control outputs 0.
